// File: rtl/pwm_capture.sv
// pwm_capture: measures an incoming PWM pulse train and reports its high time
// and rising-to-rising period in prescaled ticks (1 us by default).
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset_n    in   asynchronous active-low reset
//   pwm_in     in   asynchronous PWM input pin
//   high_time  out  last complete measured high time, ticks
//   period     out  last complete measured period, ticks
//   valid      out  one-clk pulse when high_time/period update
//   no_signal  out  1 while no complete measurement is current
module pwm_capture #(
    parameter int unsigned SYS_FREQ  = 100_000_000,
    parameter int unsigned TICK_FREQ = 1_000_000,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned TIMEOUT   = 50_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             valid,
    output logic             no_signal
);

    localparam int unsigned Div   = SYS_FREQ / TICK_FREQ;
    localparam int unsigned PresW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [PresW-1:0] PresMax    = PresW'(Div - 1);
    localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        StSync = 2'd0,
        StHigh = 2'd1,
        StLow  = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizer and edge detection
    // ------------------------------------------------------------------
    logic       sync1_q, sync2_q, prev_q;
    logic [1:0] prime_q, prime_d;
    logic       edge_en, rise, fall;

    // The synchronizer chain starts cleared, so a pin that is already high at
    // reset release would look like a rising edge. Edges are ignored until the
    // chain and the previous-value register hold real pin samples.
    assign prime_d = (prime_q == 2'd3) ? prime_q : prime_q + 2'd1;
    assign edge_en = (prime_q == 2'd3);
    assign rise    = edge_en & sync2_q & ~prev_q;
    assign fall    = edge_en & ~sync2_q & prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            prime_q <= 2'd0;
        end else begin
            sync1_q <= pwm_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            prime_q <= prime_d;
        end
    end

    // ------------------------------------------------------------------
    // Free-running tick prescaler (not resynchronised to edges)
    // ------------------------------------------------------------------
    logic [PresW-1:0] presc_q, presc_d;
    logic             tick;

    assign tick    = (presc_q == PresMax);
    assign presc_d = tick ? '0 : presc_q + PresW'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    // ------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------
    state_e           state_q, state_d;
    logic [CNT_W-1:0] p_cnt_q, p_cnt_d;
    logic [CNT_W-1:0] h_lat_q, h_lat_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             no_signal_q, no_signal_d;
    logic [CNT_W-1:0] p_cnt_inc;
    logic             timed_out;

    // Count including this cycle's tick; saturates instead of wrapping.
    assign p_cnt_inc = (tick && (p_cnt_q != CntMax)) ? p_cnt_q + CNT_W'(1) : p_cnt_q;
    assign timed_out = (p_cnt_q >= TimeoutCnt);

    always_comb begin
        state_d     = state_q;
        p_cnt_d     = p_cnt_q;
        h_lat_d     = h_lat_q;
        high_time_d = high_time_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        no_signal_d = no_signal_q;

        unique case (state_q)
            StSync: begin
                p_cnt_d = '0;
                if (rise) begin
                    state_d = StHigh;
                end
            end
            StHigh: begin
                p_cnt_d = p_cnt_inc;
                if (fall) begin
                    h_lat_d = p_cnt_inc;
                    state_d = StLow;
                end else if (timed_out) begin
                    state_d     = StSync;
                    p_cnt_d     = '0;
                    high_time_d = '0;
                    period_d    = '0;
                    no_signal_d = 1'b1;
                end
            end
            StLow: begin
                p_cnt_d = p_cnt_inc;
                // A rise beats a simultaneous timeout and completes the measurement.
                if (rise) begin
                    high_time_d = h_lat_q;
                    period_d    = p_cnt_inc;
                    valid_d     = 1'b1;
                    no_signal_d = 1'b0;
                    p_cnt_d     = '0;
                    state_d     = StHigh;
                end else if (timed_out) begin
                    state_d     = StSync;
                    p_cnt_d     = '0;
                    high_time_d = '0;
                    period_d    = '0;
                    no_signal_d = 1'b1;
                end
            end
            default: begin
                state_d = StSync;
                p_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StSync;
            p_cnt_q     <= '0;
            h_lat_q     <= '0;
            high_time_q <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            no_signal_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            p_cnt_q     <= p_cnt_d;
            h_lat_q     <= h_lat_d;
            high_time_q <= high_time_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            no_signal_q <= no_signal_d;
        end
    end

    assign high_time = high_time_q;
    assign period    = period_q;
    assign valid     = valid_q;
    assign no_signal = no_signal_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed test of pwm_capture with a 4-clk tick so that a
// scaled servo wave (15 ticks high / 100 ticks period) runs quickly. Pin edges
// are spaced by whole ticks, so measurements come out exact.
module tb_pwm_capture;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned TIMEOUT = 300;

    logic             clk;
    logic             reset_n;
    logic             pwm_in;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] period;
    logic             valid;
    logic             no_signal;

    int n_cmp  = 0;
    int n_fail = 0;

    // Observation of valid pulses
    int               vcnt = 0;
    logic [CNT_W-1:0] last_h = '0;
    logic [CNT_W-1:0] last_p = '0;
    int               v0;

    pwm_capture #(
        .SYS_FREQ (4),
        .TICK_FREQ(1),
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .pwm_in   (pwm_in),
        .high_time(high_time),
        .period   (period),
        .valid    (valid),
        .no_signal(no_signal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid) begin
            vcnt   <= vcnt + 1;
            last_h <= high_time;
            last_p <= period;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic lvl, input int nclk);
        pwm_in = lvl;
        repeat (nclk) @(negedge clk);
    endtask

    initial begin
        pwm_in  = 1'b0;
        reset_n = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_high_time", int'(high_time), 0);
        check("rst_period", int'(period), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_no_signal", int'(no_signal), 1);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: 15/100 tick wave, first valid at the second rise
        drive(1'b1, 60);
        drive(1'b0, 340);
        check("t1_no_valid_first_rise", vcnt, 0);
        check("t1_no_signal_before", int'(no_signal), 1);
        drive(1'b1, 60);
        check("t1_valid_count1", vcnt, 1);
        check("t1_high", int'(last_h), 15);
        check("t1_period", int'(last_p), 100);
        check("t1_no_signal_after", int'(no_signal), 0);
        drive(1'b0, 340);
        drive(1'b1, 60);
        check("t1_valid_count2", vcnt, 2);
        check("t1_high2", int'(high_time), 15);
        check("t1_period2", int'(period), 100);

        // 2: sweep to 10 ticks then 20 ticks high
        drive(1'b0, 340);
        drive(1'b1, 40);
        check("t2_old_high", int'(last_h), 15);
        drive(1'b0, 360);
        drive(1'b1, 80);
        check("t2_high_10", int'(last_h), 10);
        check("t2_period_10", int'(last_p), 100);
        drive(1'b0, 320);
        drive(1'b1, 80);
        check("t2_high_20", int'(last_h), 20);
        check("t2_period_20", int'(last_p), 100);
        check("t2_valid_count", vcnt, 5);

        // 3: hold low -> timeout about 1200 clk after the last rise
        v0 = vcnt;
        drive(1'b0, 1000);
        check("t3_before_timeout_ns", int'(no_signal), 0);
        check("t3_before_timeout_h", int'(high_time), 20);
        drive(1'b0, 300);
        check("t3_timeout_ns", int'(no_signal), 1);
        check("t3_timeout_h", int'(high_time), 0);
        check("t3_timeout_p", int'(period), 0);
        check("t3_timeout_novalid", vcnt, v0);
        drive(1'b1, 60);
        drive(1'b0, 340);
        check("t3_restart_first_rise", vcnt, v0);
        drive(1'b1, 60);
        check("t3_restart_valid", vcnt, v0 + 1);
        check("t3_restart_high", int'(last_h), 15);
        check("t3_restart_period", int'(last_p), 100);
        check("t3_restart_ns", int'(no_signal), 0);

        // 4: hold high -> timeout, later fall ignored
        drive(1'b0, 340);
        drive(1'b1, 60);
        v0 = vcnt;
        drive(1'b1, 1200);
        check("t4_timeout_ns", int'(no_signal), 1);
        check("t4_timeout_h", int'(high_time), 0);
        check("t4_timeout_p", int'(period), 0);
        drive(1'b0, 340);
        check("t4_fall_ignored_ns", int'(no_signal), 1);
        check("t4_fall_ignored_v", vcnt, v0);
        drive(1'b1, 60);
        drive(1'b0, 340);
        check("t4_first_rise", vcnt, v0);
        drive(1'b1, 60);
        check("t4_valid", vcnt, v0 + 1);
        check("t4_high", int'(last_h), 15);
        check("t4_period", int'(last_p), 100);

        // 5: narrow 2/10 tick pulses
        drive(1'b0, 340);
        v0 = vcnt;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8);
            drive(1'b0, 32);
        end
        drive(1'b1, 8);
        check("t5_valid_count", vcnt, v0 + 6);
        check("t5_high", int'(last_h), 2);
        check("t5_period", int'(last_p), 10);

        // 6: reset mid-HIGH with the pin still high at release
        drive(1'b1, 20);
        reset_n = 1'b0;
        repeat (5) @(negedge clk);
        check("t6_rst_high", int'(high_time), 0);
        check("t6_rst_period", int'(period), 0);
        check("t6_rst_valid", int'(valid), 0);
        check("t6_rst_ns", int'(no_signal), 1);
        reset_n = 1'b1;
        v0 = vcnt;
        drive(1'b1, 40);
        drive(1'b0, 300);
        check("t6_held_high_no_valid", vcnt, v0);
        drive(1'b1, 60);
        drive(1'b0, 340);
        check("t6_first_rise", vcnt, v0);
        check("t6_first_rise_ns", int'(no_signal), 1);
        drive(1'b1, 60);
        check("t6_valid", vcnt, v0 + 1);
        check("t6_high", int'(last_h), 15);
        check("t6_period", int'(last_p), 100);
        check("t6_ns", int'(no_signal), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
Measures an incoming PWM pulse train, such as an RC/SG90 servo command or the output of our pwm_Nfreq_Nstep generators, and reports its high time and period in microsecond ticks. It is the decoder for the PWM generator: the generator turns a duty value into a waveform, and this block turns the waveform back into numbers. Its outputs feed bin_to_dec/FND_cntr for display, or control logic that reacts to an external PWM source.

Parameters:
SYS_FREQ, 100_000_000, system clock frequency in Hz.
TICK_FREQ, 1_000_000, measurement resolution in Hz (default 1 us per tick).
CNT_W, 16, width of the tick counters and measurement outputs.
TIMEOUT, 50_000, ticks without a rising edge before the input is declared dead. Must be ≤ 2^CNT_W-1.

Ports:
clk  in  1  system clock; all logic on posedge clk.
reset_n  in  1  asynchronous, active-low reset.
pwm_in  in  1  asynchronous PWM input pin.
high_time  out  CNT_W  last complete measured high time, in ticks.
period  out  CNT_W  last complete measured rising-to-rising period, in ticks.
valid  out  1  one-clk pulse when high_time/period update.
no_signal  out  1  level; 1 while no complete measurement is current.

Behaviour:
- Reset (reset_n=0, async): all registers cleared. high_time=0, period=0, valid=0, no_signal=1, state=SYNC, prescaler=0.
- Input path: 2-FF synchronizer, then a previous-value register. rise = sync & ~prev, fall = ~sync & prev; each is a 1-clk pulse. Latency from pin edge to rise/fall pulse is 3 clk.
- Prescaler: free-running counter 0..SYS_FREQ/TICK_FREQ-1 that emits a 1-clk tick at the terminal count and wraps to 0. It is not resynchronised to edges, so the quantization error is ±1 tick.
- Counters:
  - p_cnt counts ticks since the last rise.
  - h_lat captures p_cnt at fall.
  - p_cnt saturates at all-ones and never wraps.
- FSM states SYNC, HIGH, LOW:
  - SYNC: p_cnt held at 0; fall ignored. On rise: p_cnt<=0, go to HIGH. Any partial first pulse is discarded.
  - HIGH: p_cnt increments on tick. On fall: h_lat<=p_cnt (including that cycle's tick if present), go to LOW.
  - LOW: p_cnt increments on tick. On rise: high_time<=h_lat, period<=p_cnt (including that cycle's tick if present), valid<=1 for one clk, no_signal<=0, p_cnt<=0, go to HIGH.
- Edge/tick coincidence on a rise: the counter restart to 0 wins, so the new period starts at 0.
- The first valid pulse arrives after the second rising edge seen following reset or timeout.
- Timeout: in HIGH or LOW, when p_cnt reaches TIMEOUT, the input is stuck high or stuck low. Then, in one clk: state<=SYNC, high_time<=0, period<=0, no_signal<=1, valid stays 0. A timeout and a rise in the same clk: the rise wins and a normal measurement completes.
- Outputs hold their last values between valid pulses. valid is never asserted in SYNC.
- Constant-high input from reset: stays in SYNC, no_signal=1.
- 100% or 0% duty after lock: resolved by the timeout rule.
- Reset mid-pulse: immediate return to reset values. The pulse in progress is never reported.

Test Plan:
1. SYS_FREQ=100M, TICK_FREQ=1M, 1.5 ms high / 20 ms period servo wave, 3 cycles → valid pulses start at the 2nd rise, one per period. high_time=1500±1, period=20000±1; no_signal drops to 0 at the first valid.
2. Sweep servo 1.0 ms then 2.0 ms high at 20 ms → high_time updates to 1000±1 then 2000±1 on the first valid after each change; period stays 20000±1.
3. Lock on 1.5/20 ms, then hold pwm_in low → at TIMEOUT=50000 ticks after the last rise: no_signal=1, high_time=0, period=0, no valid. Restart the wave → first valid after the second rise.
4. Lock, then hold pwm_in high → same timeout response measured from the last rise; a later fall is ignored in SYNC.
5. Narrow pulses, 2 us high / 10 us period → high_time=2±1, period=10±1, valid every 10 us.
6. Assert reset_n=0 mid-HIGH for 5 clk, then release → outputs 0/0/0, no_signal=1 during reset. The next valid appears only after two full rising edges, with correct values.
